// File: rtl/tone_pkg.sv
// Shared types and widths for the tone sequencer.
// Holds the FSM state encoding and the note-table entry layout.
package tone_pkg;

    localparam int PERIOD_W = 26;
    localparam int DUR_W    = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    typedef struct packed {
        logic [PERIOD_W-1:0] period;
        logic [DUR_W-1:0]    dur;
    } note_t;

endpackage

// File: rtl/tone_sequencer_tick_div.sv
// Duration-tick prescaler: one-cycle tick every TICK_DIV clocks.
// clr restarts the count so a note always gets full-length ticks.
module tick_div #(
    parameter int TICK_DIV = 48000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clr || cnt_q == LAST) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/tone_sequencer.sv
// Note-table driven tone sequencer feeding a square-wave generator.
// Plays entries 0..length-1 with optional silent gaps and looping.
module tone_sequencer
    import tone_pkg::*;
#(
    parameter int TICK_DIV  = 48000,
    parameter int GAP_TICKS = 10,
    parameter int DEPTH     = 16,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [PERIOD_W-1:0] wr_period,
    input  logic [DUR_W-1:0]    wr_dur,
    input  logic [AW:0]         length,
    input  logic                loop,
    input  logic                start,
    input  logic                stop,
    output logic [PERIOD_W-1:0] period,
    output logic                tone_en,
    output logic [AW-1:0]       note_idx,
    output logic                busy,
    output logic                done
);

    localparam int LW = AW + 1;
    localparam bit NO_GAP = (GAP_TICKS == 0);
    localparam logic [DUR_W-1:0] GAP_LAST =
        DUR_W'((GAP_TICKS == 0) ? 0 : GAP_TICKS - 1);

    note_t table_q [DEPTH];
    note_t table_d [DEPTH];

    state_e              state_q, state_d;
    logic [AW-1:0]       note_idx_q, note_idx_d;
    logic [DUR_W-1:0]    tcnt_q, tcnt_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic                tone_en_q, tone_en_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic             tick;
    logic             enter;
    logic             adv;
    logic             play_end;
    logic             gap_end;
    logic             has_next;
    logic [DUR_W-1:0] cur_dur;

    tick_div #(
        .TICK_DIV(TICK_DIV)
    ) u_tick_div (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (enter),
        .tick (tick)
    );

    always_comb begin
        table_d = table_q;
        if (wr_en) begin
            table_d[wr_addr] = '{period: wr_period, dur: wr_dur};
        end
    end

    assign cur_dur  = table_q[note_idx_q].dur;
    assign play_end = (cur_dur == '0) ||
                      (tick && tcnt_q == cur_dur - DUR_W'(1));
    assign gap_end  = tick && (tcnt_q == GAP_LAST);
    assign has_next = ({1'b0, note_idx_q} + LW'(1)) < length;

    always_comb begin
        state_d    = state_q;
        note_idx_d = note_idx_q;
        tcnt_d     = tick ? tcnt_q + DUR_W'(1) : tcnt_q;
        enter      = 1'b0;
        adv        = 1'b0;
        done_d     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start && length != '0) begin
                    state_d    = ST_PLAY;
                    note_idx_d = '0;
                    enter      = 1'b1;
                end
            end
            ST_PLAY: begin
                if (play_end) begin
                    if (NO_GAP) begin
                        adv = 1'b1;
                    end else begin
                        state_d = ST_GAP;
                        enter   = 1'b1;
                    end
                end
            end
            ST_GAP: begin
                adv = gap_end;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (adv) begin
            if (has_next) begin
                state_d    = ST_PLAY;
                note_idx_d = note_idx_q + AW'(1);
                enter      = 1'b1;
            end else if (loop) begin
                state_d    = ST_PLAY;
                note_idx_d = '0;
                enter      = 1'b1;
            end else begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
        end

        // Abort overrides start and any advance decided this cycle.
        if (stop) begin
            state_d    = ST_IDLE;
            note_idx_d = note_idx_q;
            enter      = 1'b0;
            done_d     = 1'b0;
        end

        if (enter || state_d == ST_IDLE) begin
            tcnt_d = '0;
        end

        // table_d forwards a same-cycle write to the playing entry.
        period_d  = (state_d == ST_PLAY) ? table_d[note_idx_d].period
                                         : period_q;
        tone_en_d = (state_d == ST_PLAY) && (period_d != '0);
        busy_d    = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                table_q[i] <= '0;
            end
            state_q    <= ST_IDLE;
            note_idx_q <= '0;
            tcnt_q     <= '0;
            period_q   <= '0;
            tone_en_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            table_q    <= table_d;
            state_q    <= state_d;
            note_idx_q <= note_idx_d;
            tcnt_q     <= tcnt_d;
            period_q   <= period_d;
            tone_en_q  <= tone_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign period   = period_q;
    assign tone_en  = tone_en_q;
    assign note_idx = note_idx_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_tone_sequencer.sv
// Directed bench for tone_sequencer with TICK_DIV=4, GAP_TICKS=1.
// Expected traces are hand-derived from the note table timings.
module tb_tone_sequencer;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk;
    logic          rst_n;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [25:0]   wr_period;
    logic [15:0]   wr_dur;
    logic [AW:0]   length;
    logic          loop;
    logic          start;
    logic          stop;
    logic [25:0]   period;
    logic          tone_en;
    logic [AW-1:0] note_idx;
    logic          busy;
    logic          done;

    int n_chk;
    int n_pass;

    tone_sequencer #(
        .TICK_DIV (4),
        .GAP_TICKS(1),
        .DEPTH    (DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_period(wr_period),
        .wr_dur   (wr_dur),
        .length   (length),
        .loop     (loop),
        .start    (start),
        .stop     (stop),
        .period   (period),
        .tone_en  (tone_en),
        .note_idx (note_idx),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [25:0] p,
                      input logic [15:0] d);
        wr_en     = 1'b1;
        wr_addr   = a;
        wr_period = p;
        wr_dur    = d;
        step();
        wr_en = 1'b0;
    endtask

    function automatic logic [63:0] pk(input logic b, input logic t,
                                       input logic dn,
                                       input logic [AW-1:0] i,
                                       input logic [25:0] p);
        return {31'd0, b, t, dn, i, p};
    endfunction

    task automatic seg(input string tag, input int len, input logic b,
                       input logic t, input logic dn,
                       input logic [AW-1:0] i, input logic [25:0] p);
        for (int c = 0; c < len; c++) begin
            chk(tag, pk(busy, tone_en, done, note_idx, period),
                pk(b, t, dn, i, p));
            step();
        end
    endtask

    initial begin
        logic seen_done;
        n_chk     = 0;
        n_pass    = 0;
        rst_n     = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_period = '0;
        wr_dur    = '0;
        length    = '0;
        loop      = 1'b0;
        start     = 1'b0;
        stop      = 1'b0;
        #2;
        chk("rst_out", pk(busy, tone_en, done, note_idx, period),
            pk(0, 0, 0, 0, 0));
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("rst_rel", {63'd0, busy}, 64'd0);

        // Basic non-looping sequence
        wr(0, 100, 2);
        wr(1, 0, 1);
        wr(2, 200, 3);
        length = 3;
        start  = 1'b1;
        step();
        start = 1'b0;
        seg("n0", 8, 1, 1, 0, 0, 100);
        seg("g0", 4, 1, 0, 0, 0, 100);
        seg("n1", 4, 1, 0, 0, 1, 0);
        seg("g1", 4, 1, 0, 0, 1, 0);
        seg("n2", 12, 1, 1, 0, 2, 200);
        seg("g2", 4, 1, 0, 0, 2, 200);
        seg("done", 1, 0, 0, 1, 2, 200);
        seg("idle", 2, 0, 0, 0, 2, 200);

        // Looping sequence, then stop mid-note
        loop  = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        seen_done = done;
        for (int c = 1; c <= 40; c++) begin
            step();
            seen_done = seen_done | done;
            if (c == 36) begin
                chk("wrap", pk(busy, tone_en, done, note_idx, period),
                    pk(1, 1, 0, 0, 100));
            end
        end
        chk("loop_nodone", {63'd0, seen_done}, 64'd0);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("stop", pk(busy, tone_en, done, note_idx, period),
            pk(0, 0, 0, 0, 100));
        step();
        chk("stop_nodone", {63'd0, done}, 64'd0);
        loop = 1'b0;

        // start+stop together, and length=0
        start = 1'b1;
        stop  = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b0;
        chk("st_sp", {62'd0, busy, tone_en}, 64'd0);
        length = 0;
        start  = 1'b1;
        step();
        start = 1'b0;
        chk("len0", {62'd0, busy, done}, 64'd0);
        step();
        chk("len0_b", {62'd0, busy, done}, 64'd0);

        // Asynchronous reset mid-note
        length = 3;
        start  = 1'b1;
        step();
        start = 1'b0;
        step();
        chk("pre_rst", pk(busy, tone_en, done, note_idx, period),
            pk(1, 1, 0, 0, 100));
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst", {37'd0, busy, tone_en, period}, 64'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("rst_idle", {63'd0, busy}, 64'd0);
        length = 1;
        start  = 1'b1;
        step();
        start = 1'b0;
        chk("tbl_clr", pk(busy, tone_en, done, note_idx, period),
            pk(1, 0, 0, 0, 0));
        stop = 1'b1;
        step();
        stop = 1'b0;

        // dur=0 plays for exactly one cycle
        wr(0, 300, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        seg("d0_play", 1, 1, 1, 0, 0, 300);
        seg("d0_gap", 4, 1, 0, 0, 0, 300);
        seg("d0_done", 1, 0, 0, 1, 0, 300);

        // Write to the playing entry shows on period the next cycle
        wr(0, 400, 2);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("wp_pre", {38'd0, period}, 64'd400);
        wr(0, 500, 2);
        chk("wp_post", {37'd0, tone_en, period}, {37'd0, 1'b1, 26'd500});
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("wp_stop", {62'd0, busy, tone_en}, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
